// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage ahead of the register file: RAW scoreboard, operand capture, issue bundle.
// Optional writeback-to-operand bypass is enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [4:0]  rf_addr1,
    output logic [4:0]  rf_addr2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_op_a,
    output logic [31:0] out_op_b,
    output logic [4:0]  out_dest,
    output logic        out_we
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_instr_q;
    logic [31:0] r_busy;
    logic [31:0] r_out_instr;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [4:0]  r_dest;
    logic        r_we;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_uses_rt;
    logic        w_dest_rd;
    logic        w_dest_rt;
    logic [4:0]  w_dest;
    logic        w_we;
    logic        w_byp_a;
    logic        w_byp_b;
    logic        w_haz_a;
    logic        w_haz_b;
    logic        w_issue;
    logic        w_accept;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [1:0]  w_state_nxt;

    assign w_op = r_instr_q[31:26];
    assign w_rs = r_instr_q[25:21];
    assign w_rt = r_instr_q[20:16];
    assign w_rd = r_instr_q[15:11];

    assign w_uses_rt = (w_op == 6'h00) | (w_op == 6'h04) | (w_op == 6'h05) | (w_op == 6'h2B);
    assign w_dest_rd = (w_op == 6'h00);
    // ops 0x08..0x0F share op[5:3]==3'b001
    assign w_dest_rt = (w_op[5:3] == 3'b001) | (w_op == 6'h23);
    assign w_dest    = w_dest_rd ? w_rd : (w_dest_rt ? w_rt : 5'd0);
    assign w_we      = (w_dest_rd | w_dest_rt) & (w_dest != 5'd0);

`ifdef OPFETCH_BYPASS_EN
    assign w_byp_a = wb_valid & (wb_addr == w_rs) & (w_rs != 5'd0);
    assign w_byp_b = wb_valid & (wb_addr == w_rt) & (w_rt != 5'd0);
`else
    logic w_unused_wb_data;
    assign w_unused_wb_data = ^wb_data;
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    // Hazards look only at registered busy; a bypass forwards the retiring value instead.
    assign w_haz_a  = (w_rs != 5'd0) & r_busy[w_rs] & ~w_byp_a;
    assign w_haz_b  = w_uses_rt & (w_rt != 5'd0) & r_busy[w_rt] & ~w_byp_b;
    assign w_issue  = (r_state == S_CHECK) & ~w_haz_a & ~w_haz_b;
    assign w_op_a   = w_byp_a ? wb_data : rf_data1;
    assign w_op_b   = w_byp_b ? wb_data : rf_data2;

    assign in_ready = (r_state == S_EMPTY) | ((r_state == S_VALID) & out_ready);
    assign w_accept = in_valid & in_ready;

    assign w_clr = wb_valid ? (32'd1 << wb_addr) : 32'd0;
    assign w_set = (w_issue & w_we) ? (32'd1 << w_dest) : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (in_valid) w_state_nxt = S_CHECK;
            S_CHECK: if (w_issue) w_state_nxt = S_VALID;
            S_VALID: if (out_ready) w_state_nxt = in_valid ? S_CHECK : S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_instr_q   <= 32'd0;
            r_busy      <= 32'd0;
            r_out_instr <= 32'd0;
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_dest      <= 5'd0;
            r_we        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // set after clear so a same-cycle issue keeps the register busy
            r_busy  <= (r_busy & ~w_clr) | w_set;
            if (w_accept) r_instr_q <= in_instr;
            if (w_issue) begin
                r_out_instr <= r_instr_q;
                r_op_a      <= w_op_a;
                r_op_b      <= w_op_b;
                r_dest      <= w_dest;
                r_we        <= w_we;
            end
        end
    end

    assign rf_addr1  = w_rs;
    assign rf_addr2  = w_rt;
    assign out_valid = (r_state == S_VALID);
    assign out_instr = r_out_instr;
    assign out_op_a  = r_op_a;
    assign out_op_b  = r_op_b;
    assign out_dest  = r_dest;
    assign out_we    = r_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch against a scoreboard/register-file reference model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  rf_addr1, rf_addr2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr, out_op_a, out_op_b;
    logic [4:0]  out_dest;
    logic        out_we;

    operand_fetch dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_dest(out_dest), .out_we(out_we)
    );

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    // register file environment: negedge read, posedge write from writeback
    logic [31:0] rf [32];
    always @(negedge clk) begin
        rf_data1 <= rf[rf_addr1];
        rf_data2 <= rf[rf_addr2];
    end
    always @(posedge clk) if (wb_valid && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_busy;
    bit          pending;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_uses_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B;
    endfunction

    // {exists, register}
    function automatic logic [5:0] m_dest(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h00) return {1'b1, ins[15:11]};
        if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23) return {1'b1, ins[20:16]};
        return 6'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1 chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b0;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_empty_ready", {31'd0, in_ready}, 32'd1);
        pending = 1'b0;
    endtask

    // Offer ins, resolve hazards by retiring blockers after `delay` CHECK cycles, then hold.
    task automatic run_instr(input logic [31:0] ins, input int delay, input int hold,
                             input logic [4:0] xwb, output int cycles);
        logic [4:0]  rs, rt, dst;
        logic [5:0]  dd;
        logic [31:0] ea, eb;
        bit          urt, we, issued, byp_a, byp_b, haz_a, haz_b;
        rs  = ins[25:21];
        rt  = ins[20:16];
        urt = m_uses_rt(ins[31:26]);
        dd  = m_dest(ins);
        dst = dd[4:0];
        we  = dd[5] && dst != 5'd0;
        ea  = 32'd0;
        eb  = 32'd0;
        in_valid  = 1'b1;
        in_instr  = ins;
        out_ready = pending;
        #1 chk("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pending   = 1'b0;
        chk("accept_ov", {31'd0, out_valid}, 32'd0);
        chk("rf_addr1", {27'd0, rf_addr1}, {27'd0, rs});
        chk("rf_addr2", {27'd0, rf_addr2}, {27'd0, rt});
        issued = 1'b0;
        cycles = 0;
        for (int c = 0; c < 12 && !issued; c++) begin
            wb_valid = 1'b0;
            wb_addr  = 5'd0;
            wb_data  = 32'd0;
            if (c >= delay) begin
                if (rs != 0 && m_busy[rs]) begin wb_valid = 1'b1; wb_addr = rs; end
                else if (urt && rt != 0 && m_busy[rt]) begin wb_valid = 1'b1; wb_addr = rt; end
                else if (c == delay && xwb != 0) begin wb_valid = 1'b1; wb_addr = xwb; end
                if (wb_valid) wb_data = $urandom;
            end
            byp_a  = BYP && wb_valid && wb_addr == rs && rs != 0;
            byp_b  = BYP && wb_valid && wb_addr == rt && rt != 0;
            haz_a  = rs != 0 && m_busy[rs] && !byp_a;
            haz_b  = urt && rt != 0 && m_busy[rt] && !byp_b;
            issued = !(haz_a || haz_b);
            ea     = byp_a ? wb_data : rf[rs];
            eb     = byp_b ? wb_data : rf[rt];
            cycles++;
            tick();
            if (wb_valid) m_busy[wb_addr] = 1'b0;
            if (issued && we) m_busy[dst] = 1'b1;
            chk("check_ov", {31'd0, out_valid}, {31'd0, issued});
            chk("check_in_ready", {31'd0, in_ready}, 32'd0);
        end
        wb_valid = 1'b0;
        if (!issued) chk("issue_timeout", 32'd0, 32'd1);
        chk("out_instr", out_instr, ins);
        chk("out_op_a", out_op_a, ea);
        chk("out_op_b", out_op_b, eb);
        chk("out_dest", {27'd0, out_dest}, {27'd0, dd[5] ? dst : 5'd0});
        chk("out_we", {31'd0, out_we}, {31'd0, we});
        chk("busy", dut.r_busy, m_busy);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_instr = $urandom;
            tick();
            chk("hold_ov", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_instr", out_instr, ins);
            chk("hold_op_a", out_op_a, ea);
            chk("hold_op_b", out_op_b, eb);
            chk("hold_dest", {27'd0, out_dest}, {27'd0, dd[5] ? dst : 5'd0});
        end
        in_valid = 1'b0;
        pending  = issued;
    endtask

    logic [5:0] ops [8];
    initial begin
        int          cyc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] ins;
        ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h0D, 6'h23, 6'h02};
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        rf[9]  = 32'd5;
        rf[10] = 32'd7;
        reset = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        m_busy = 32'd0; pending = 1'b0;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rf_addr", {22'd0, rf_addr1, rf_addr2}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_ops", out_op_a | out_op_b, 32'd0);
        chk("rst_dest_we", {26'd0, out_dest, out_we}, 32'd0);
        chk("rst_busy", dut.r_busy, 32'd0);
        reset = 1'b1;
        tick();

        // add $8,$9,$10 : one CHECK cycle, then bundle
        run_instr(32'h012A4020, 0, 0, 5'd0, cyc);
        chk("t1_cycles", cyc, 1);
        chk("t1_op_a", out_op_a, 32'd5);
        chk("t1_op_b", out_op_b, 32'd7);
        chk("t1_dest", {27'd0, out_dest}, 32'd8);
        chk("t1_busy8", {31'd0, dut.r_busy[8]}, 32'd1);

        // add $10,$8,$9 : stalls on $8, retired after 3 stall cycles; then hold 5
        run_instr(32'h01095020, 3, 5, 5'd0, cyc);
        chk("t2_cycles", cyc, BYP ? 4 : 5);
        chk("t2_op_a_wb", out_op_a, rf[8]);
        chk("t2_op_b", out_op_b, 32'd5);

        // fill busy 1..31 with addi $r,$0,0, each accepted straight out of VALID
        for (int r = 1; r < 32; r++) run_instr(32'h20000000 | (r << 16), 0, 0, 5'd0, cyc);
        chk("all_busy", dut.r_busy, 32'hFFFF_FFFE);
        run_instr(32'h0000_0000, 0, 0, 5'd0, cyc);
        chk("r0_no_stall", cyc, 1);

        // addi $3,$0,1 issuing while writeback retires $3: set wins
        run_instr(32'h2003_0001, 0, 1, 5'd3, cyc);
        chk("set_wins_busy3", {31'd0, dut.r_busy[3]}, 32'd1);

        // reset in the middle of a stall on $8
        chk("pre_rst_busy8", {31'd0, m_busy[8]}, 32'd1);
        drain();
        in_valid = 1'b1;
        in_instr = 32'h01095020;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_stall", {31'd0, out_valid}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", dut.r_busy, 32'd0);
        chk("mid_rst_rf_addr", {27'd0, rf_addr1}, 32'd0);
        tick();
        reset = 1'b1;
        m_busy = 32'd0;
        pending = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            ins = {ops[$urandom_range(0, 7)], rs, rt, rd, 11'($urandom)};
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 5'd0, cyc);
            if ($urandom_range(0, 1) == 1) drain();
        end
        if (pending) drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
